// File: rtl/battle_ctrl_fsm_if.sv
// Handshake and status bundle between the battle controller and its
// READY/judge/input/display neighbours.
interface battle_ctrl_fsm_if #(
  parameter int unsigned HP_W    = 2,
  parameter int unsigned ROUND_W = 4
) ();

  logic               OK_IN;
  logic               QUE;
  logic               QUE_IN;
  logic               WRONG_IN;
  logic               JUDG_VLD;
  logic [1:0]         JUDG_IN;

  logic [3:0]         STATE;
  logic [HP_W-1:0]    HP1;
  logic [HP_W-1:0]    HP2;
  logic [ROUND_W-1:0] ROUND;
  logic [7:0]         SEC_LEFT;
  logic               TICK_1HZ;
  logic               GAME_END;

  // Surrounding modules drive the requests and observe the status
  modport master (
    output OK_IN, QUE, QUE_IN, WRONG_IN, JUDG_VLD, JUDG_IN,
    input  STATE, HP1, HP2, ROUND, SEC_LEFT, TICK_1HZ, GAME_END
  );

  modport slave (
    input  OK_IN, QUE, QUE_IN, WRONG_IN, JUDG_VLD, JUDG_IN,
    output STATE, HP1, HP2, ROUND, SEC_LEFT, TICK_1HZ, GAME_END
  );

endinterface

// File: rtl/battle_ctrl_fsm.sv
// Game-flow controller for the two-player factorization battle: state sequencing,
// answer time limit, timed result screens and HP/round bookkeeping.
module battle_ctrl_fsm #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned RESULT_SEC = 1,
  parameter int unsigned WRONG_SEC  = 1,
  parameter int unsigned ANSWER_SEC = 30,
  parameter int unsigned HP_MAX     = 3,
  parameter int unsigned HP_W       = 2,
  parameter int unsigned ROUND_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  battle_ctrl_fsm_if.slave bus
);

  localparam logic [3:0] S_READY    = 4'b0010;
  localparam logic [3:0] S_QUESTION = 4'b0011;
  localparam logic [3:0] S_INPUT    = 4'b0100;
  localparam logic [3:0] S_DRAW     = 4'b0110;
  localparam logic [3:0] S_WRONG    = 4'b0111;
  localparam logic [3:0] S_GOOD     = 4'b1000;
  localparam logic [3:0] S_OUCH     = 4'b1001;
  localparam logic [3:0] S_WIN      = 4'b1010;
  localparam logic [3:0] S_LOSE     = 4'b1011;
  localparam logic [3:0] S_TIMEOUT  = 4'b1100;

  localparam int unsigned PRESC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned HOLD_MAX = (RESULT_SEC > WRONG_SEC) ? RESULT_SEC : WRONG_SEC;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [PRESC_W-1:0] PRESC_TC   = PRESC_W'(CLK_HZ - 1);
  localparam logic [HOLD_W-1:0]  RES_LAST   = HOLD_W'(RESULT_SEC - 1);
  localparam logic [HOLD_W-1:0]  WRONG_LAST = HOLD_W'(WRONG_SEC - 1);
  localparam logic [7:0]         SEC_INIT   = 8'(ANSWER_SEC);
  localparam logic [HP_W-1:0]    HP_FULL    = HP_W'(HP_MAX);

  logic [3:0]         state,      state_n;
  logic [HP_W-1:0]    hp1,        hp1_n;
  logic [HP_W-1:0]    hp2,        hp2_n;
  logic [ROUND_W-1:0] round_cnt,  round_n;
  logic [7:0]         sec_left,   sec_left_n;
  logic [PRESC_W-1:0] presc,      presc_n;
  logic [HOLD_W-1:0]  hold_sec,   hold_sec_n;
  logic               view,       view_n;
  logic               que_in_q;
  logic               tick_q,     tick_n;
  logic               game_end_q, game_end_n;

  logic               tick_c;
  logic               que_rise_c;
  logic               answering_c;
  logic               timeout_c;
  logic               hold_done_c;
  logic               entering_c;
  logic [HOLD_W-1:0]  hold_last_c;

  function automatic logic is_answer(input logic [3:0] s);
    return (s == S_QUESTION) || (s == S_INPUT);
  endfunction

  function automatic logic is_hold(input logic [3:0] s);
    return (s == S_WRONG) || (s == S_GOOD) || (s == S_OUCH) || (s == S_DRAW) ||
           (s == S_WIN)   || (s == S_LOSE) || (s == S_TIMEOUT);
  endfunction

  function automatic logic is_timed(input logic [3:0] s);
    return is_answer(s) || is_hold(s);
  endfunction

  // Next-state, bookkeeping and timer logic
  always_comb begin
    state_n     = state;
    hp1_n       = hp1;
    hp2_n       = hp2;
    round_n     = round_cnt;
    sec_left_n  = sec_left;
    presc_n     = '0;
    hold_sec_n  = '0;
    view_n      = 1'b0;
    tick_n      = 1'b0;
    game_end_n  = 1'b0;

    tick_c      = (presc == PRESC_TC);
    que_rise_c  = bus.QUE_IN & ~que_in_q;
    answering_c = is_answer(state);
    timeout_c   = answering_c && tick_c && (sec_left == 8'd1);
    hold_last_c = (state == S_WRONG) ? WRONG_LAST : RES_LAST;
    hold_done_c = tick_c && (hold_sec == hold_last_c);

    case (state)
      S_READY: begin
        if (bus.OK_IN && bus.QUE) begin
          state_n    = S_QUESTION;
          sec_left_n = SEC_INIT;
        end
      end
      S_QUESTION: begin
        if (timeout_c)              state_n = S_TIMEOUT;
        else if (view && bus.QUE)   state_n = S_INPUT;
      end
      S_INPUT: begin
        if (bus.WRONG_IN)                               state_n = S_WRONG;
        else if (bus.JUDG_VLD && bus.JUDG_IN == 2'b01)  state_n = S_GOOD;
        else if (bus.JUDG_VLD && bus.JUDG_IN == 2'b10)  state_n = S_OUCH;
        else if (bus.JUDG_VLD && bus.JUDG_IN == 2'b11)  state_n = S_DRAW;
        else if (timeout_c)                             state_n = S_TIMEOUT;
        else if (!view && bus.QUE)                      state_n = S_QUESTION;
      end
      S_WRONG: begin
        if (hold_done_c) state_n = S_INPUT;
      end
      S_GOOD: begin
        if (hold_done_c) state_n = (hp2 == '0) ? S_WIN : S_READY;
      end
      S_OUCH: begin
        if (hold_done_c) state_n = (hp1 == '0) ? S_LOSE : S_READY;
      end
      S_DRAW, S_TIMEOUT: begin
        if (hold_done_c) state_n = S_READY;
      end
      S_WIN, S_LOSE: begin
        if (hold_done_c) begin
          state_n    = S_READY;
          hp1_n      = HP_FULL;
          hp2_n      = HP_FULL;
          round_n    = '0;
          game_end_n = 1'b1;
        end
      end
      default: state_n = S_READY;
    endcase

    entering_c = (state_n != state);

    // Result bookkeeping happens once, on the edge that enters the result screen
    if (entering_c && state_n == S_GOOD)
      hp2_n = (hp2 == '0) ? hp2 : hp2 - HP_W'(1);
    if (entering_c && state_n == S_OUCH)
      hp1_n = (hp1 == '0) ? hp1 : hp1 - HP_W'(1);
    if (entering_c && (state_n == S_GOOD || state_n == S_OUCH ||
                       state_n == S_DRAW || state_n == S_TIMEOUT))
      round_n = (round_cnt == '1) ? round_cnt : round_cnt + ROUND_W'(1);

    // Leaving for WRONG or a verdict freezes the remaining seconds
    if (answering_c && tick_c && (is_answer(state_n) || state_n == S_TIMEOUT))
      sec_left_n = sec_left - 8'd1;

    // Hold entry restarts the prescaler so a hold lasts exactly N seconds
    if (!(entering_c && is_hold(state_n)) && is_timed(state) && is_timed(state_n)) begin
      presc_n = tick_c ? '0 : presc + PRESC_W'(1);
      if (is_hold(state_n))
        hold_sec_n = tick_c ? hold_sec + HOLD_W'(1) : hold_sec;
    end
    tick_n = is_timed(state_n) && (presc_n == PRESC_TC);

    if (answering_c && is_answer(state_n))
      view_n = view ^ que_rise_c;
    else if (state == S_WRONG && state_n == S_INPUT)
      view_n = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_READY;
      hp1        <= HP_FULL;
      hp2        <= HP_FULL;
      round_cnt  <= '0;
      sec_left   <= SEC_INIT;
      presc      <= '0;
      hold_sec   <= '0;
      view       <= 1'b0;
      que_in_q   <= 1'b0;
      tick_q     <= 1'b0;
      game_end_q <= 1'b0;
    end else begin
      state      <= state_n;
      hp1        <= hp1_n;
      hp2        <= hp2_n;
      round_cnt  <= round_n;
      sec_left   <= sec_left_n;
      presc      <= presc_n;
      hold_sec   <= hold_sec_n;
      view       <= view_n;
      que_in_q   <= bus.QUE_IN;
      tick_q     <= tick_n;
      game_end_q <= game_end_n;
    end
  end

  assign bus.STATE    = state;
  assign bus.HP1      = hp1;
  assign bus.HP2      = hp2;
  assign bus.ROUND    = round_cnt;
  assign bus.SEC_LEFT = sec_left;
  assign bus.TICK_1HZ = tick_q;
  assign bus.GAME_END = game_end_q;

endmodule

// File: tb/tb_battle_ctrl_fsm.sv
// Self-checking bench for battle_ctrl_fsm: directed scenarios followed by
// randomized rounds checked against a round/second-level reference model.
module tb_battle_ctrl_fsm;

  localparam int CLK_HZ     = 10;
  localparam int RESULT_SEC = 1;
  localparam int WRONG_SEC  = 2;
  localparam int ANSWER_SEC = 3;
  localparam int HP_MAX     = 2;
  localparam int ROUND_MAX  = 15;

  localparam logic [3:0] S_READY    = 4'b0010;
  localparam logic [3:0] S_QUESTION = 4'b0011;
  localparam logic [3:0] S_INPUT    = 4'b0100;
  localparam logic [3:0] S_DRAW     = 4'b0110;
  localparam logic [3:0] S_WRONG    = 4'b0111;
  localparam logic [3:0] S_GOOD     = 4'b1000;
  localparam logic [3:0] S_OUCH     = 4'b1001;
  localparam logic [3:0] S_WIN      = 4'b1010;
  localparam logic [3:0] S_LOSE     = 4'b1011;
  localparam logic [3:0] S_TIMEOUT  = 4'b1100;

  logic CLK;
  logic RST;

  battle_ctrl_fsm_if #(.HP_W(2), .ROUND_W(4)) bus ();

  battle_ctrl_fsm #(
    .CLK_HZ(CLK_HZ), .RESULT_SEC(RESULT_SEC), .WRONG_SEC(WRONG_SEC),
    .ANSWER_SEC(ANSWER_SEC), .HP_MAX(HP_MAX), .HP_W(2), .ROUND_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: HP, rounds, seconds left and the phase within the current second
  int         m_hp1, m_hp2, m_round, m_sec, m_phase;
  bit         m_view;
  logic [3:0] m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic void model_reset();
    m_hp1 = HP_MAX; m_hp2 = HP_MAX; m_round = 0; m_sec = ANSWER_SEC; m_phase = 0;
    m_view = 1'b0; m_state = S_READY;
  endfunction

  // Cycles from now until the answer limit expires
  function automatic int rem();
    return (m_sec - 1) * CLK_HZ + (CLK_HZ - m_phase);
  endfunction

  function automatic void adv();
    if (m_phase == CLK_HZ - 1) begin
      m_phase = 0;
      m_sec--;
    end else begin
      m_phase++;
    end
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, bus.STATE, S_READY);
    chk({tag, "_hp1"}, bus.HP1, HP_MAX);
    chk({tag, "_hp2"}, bus.HP2, HP_MAX);
    chk({tag, "_round"}, bus.ROUND, 0);
    chk({tag, "_sec"}, bus.SEC_LEFT, ANSWER_SEC);
    chk({tag, "_tick"}, bus.TICK_1HZ, 0);
    chk({tag, "_gend"}, bus.GAME_END, 0);
  endtask

  task automatic chk_answer(input string tag);
    chk({tag, "_state"}, bus.STATE, m_state);
    chk({tag, "_sec"}, bus.SEC_LEFT, m_sec);
    chk({tag, "_tick"}, bus.TICK_1HZ, (m_phase == CLK_HZ - 1) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk_answer("idle");
      step();
      adv();
    end
  endtask

  task automatic go_question(input bit gate_que);
    if (gate_que) begin
      bus.QUE = 1'b0; bus.OK_IN = 1'b1;
      step();
      chk("ok_without_que", bus.STATE, S_READY);
    end
    bus.QUE = 1'b1; bus.OK_IN = 1'b1;
    step();
    bus.OK_IN = 1'b0;
    m_state = S_QUESTION; m_sec = ANSWER_SEC; m_phase = 0; m_view = 1'b0;
    chk_answer("enter_q");
  endtask

  task automatic toggle();
    bus.QUE_IN = 1'b1;
    step(); adv();
    bus.QUE_IN = 1'b0;
    step(); adv();
    m_view  = ~m_view;
    m_state = m_view ? S_INPUT : S_QUESTION;
    chk_answer("toggle");
  endtask

  task automatic hold(input logic [3:0] s, input int nsec);
    chk("hold_first", bus.STATE, s);
    repeat (nsec * CLK_HZ - 1) step();
    chk("hold_last", bus.STATE, s);
    chk("hold_tick", bus.TICK_1HZ, 1);
    step();
  endtask

  task automatic chk_ready(input string tag, input int gend);
    chk({tag, "_state"}, bus.STATE, S_READY);
    chk({tag, "_hp1"}, bus.HP1, m_hp1);
    chk({tag, "_hp2"}, bus.HP2, m_hp2);
    chk({tag, "_round"}, bus.ROUND, m_round);
    chk({tag, "_gend"}, bus.GAME_END, gend);
  endtask

  task automatic end_game(input logic [3:0] s);
    chk("end_state", bus.STATE, s);
    hold(s, RESULT_SEC);
    m_hp1 = HP_MAX; m_hp2 = HP_MAX; m_round = 0;
    chk_ready("game_end", 1);
    step();
    chk("game_end_drop", bus.GAME_END, 0);
  endtask

  task automatic resolve(input logic [1:0] code);
    logic [3:0] rs;
    bus.JUDG_VLD = 1'b1; bus.JUDG_IN = code;
    step();
    bus.JUDG_VLD = 1'b0; bus.JUDG_IN = 2'b00;
    if (m_round < ROUND_MAX) m_round++;
    if (code == 2'b01) begin
      rs = S_GOOD;
      if (m_hp2 > 0) m_hp2--;
    end else if (code == 2'b10) begin
      rs = S_OUCH;
      if (m_hp1 > 0) m_hp1--;
    end else begin
      rs = S_DRAW;
    end
    chk("verdict_state", bus.STATE, rs);
    chk("verdict_hp1", bus.HP1, m_hp1);
    chk("verdict_hp2", bus.HP2, m_hp2);
    chk("verdict_round", bus.ROUND, m_round);
    hold(rs, RESULT_SEC);
    if (code == 2'b01 && m_hp2 == 0)      end_game(S_WIN);
    else if (code == 2'b10 && m_hp1 == 0) end_game(S_LOSE);
    else                                  chk_ready("after_verdict", 0);
  endtask

  task automatic wrong_pulse(input logic [1:0] code);
    bus.WRONG_IN = 1'b1; bus.JUDG_VLD = 1'b1; bus.JUDG_IN = code;
    step();
    bus.WRONG_IN = 1'b0; bus.JUDG_VLD = 1'b0; bus.JUDG_IN = 2'b00;
    m_phase = 0;
    chk("wrong_sec", bus.SEC_LEFT, m_sec);
    chk("wrong_hp1", bus.HP1, m_hp1);
    chk("wrong_hp2", bus.HP2, m_hp2);
    hold(S_WRONG, WRONG_SEC);
    m_state = S_INPUT; m_view = 1'b1;
    chk_answer("after_wrong");
  endtask

  task automatic ignored_judge();
    bus.JUDG_VLD = 1'b1;
    bus.JUDG_IN  = (m_state == S_QUESTION) ? 2'($urandom_range(0, 3)) : 2'b00;
    step(); adv();
    bus.JUDG_VLD = 1'b0; bus.JUDG_IN = 2'b00;
    chk_answer("ignored_judge");
  endtask

  task automatic timeout_round();
    idle(rem() - 1);
    chk_answer("pre_timeout");
    step();
    if (m_round < ROUND_MAX) m_round++;
    chk("timeout_state", bus.STATE, S_TIMEOUT);
    chk("timeout_sec", bus.SEC_LEFT, 0);
    chk("timeout_hp1", bus.HP1, m_hp1);
    chk("timeout_hp2", bus.HP2, m_hp2);
    chk("timeout_round", bus.ROUND, m_round);
    hold(S_TIMEOUT, RESULT_SEC);
    chk_ready("after_timeout", 0);
  endtask

  task automatic random_round();
    int o;
    int lim;
    go_question($urandom_range(0, 3) == 0);
    for (int a = 0; a < int'($urandom_range(0, 4)); a++) begin
      if (rem() < 4) break;
      case ($urandom_range(0, 3))
        0: begin
          lim = rem() - 3;
          if (lim > 8) lim = 8;
          idle(int'($urandom_range(1, lim)));
        end
        1: toggle();
        2: if (m_state == S_INPUT) wrong_pulse(2'($urandom_range(0, 3))); else idle(1);
        default: ignored_judge();
      endcase
    end
    o = int'($urandom_range(0, 3));
    if (o == 3 || (m_state == S_QUESTION && rem() < 3)) begin
      timeout_round();
    end else begin
      if (m_state == S_QUESTION) toggle();
      resolve(2'(o + 1));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "simulation did not finish in time");
  end

  initial begin
    RST = 1'b0;
    bus.OK_IN = 1'b0; bus.QUE = 1'b0; bus.QUE_IN = 1'b0;
    bus.WRONG_IN = 1'b0; bus.JUDG_VLD = 1'b0; bus.JUDG_IN = 2'b00;
    model_reset();
    repeat (2) step();
    chk_reset("reset");
    RST = 1'b1;
    step();
    chk("ready_idle", bus.STATE, S_READY);

    // Basic flow to a GOOD verdict
    go_question(1'b1);
    toggle();
    resolve(2'b01);

    // Knock-out: second GOOD empties HP2 and ends the game
    go_question(1'b0);
    toggle();
    idle(2);
    resolve(2'b01);

    // Answer timeout after toggling the view twice
    go_question(1'b0);
    toggle();
    toggle();
    timeout_round();

    // WRONG beats a simultaneous opponent-correct verdict
    go_question(1'b0);
    toggle();
    idle(5);
    wrong_pulse(2'b10);
    resolve(2'b10);

    // Second OUCH empties HP1 and loses the game
    go_question(1'b0);
    toggle();
    resolve(2'b10);

    // Judge pulses outside INPUT and null verdicts change nothing
    go_question(1'b0);
    ignored_judge();
    toggle();
    ignored_judge();
    resolve(2'b11);

    // Round counter saturation
    for (int r = 0; r < 16; r++) begin
      go_question(1'b0);
      toggle();
      resolve(2'b11);
    end
    chk("round_saturated", bus.ROUND, ROUND_MAX);

    for (int r = 0; r < 30; r++) random_round();

    // Asynchronous reset in the middle of a round
    go_question(1'b0);
    toggle();
    idle(3);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk_reset("async_reset");
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("post_reset_state", bus.STATE, S_READY);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
